axi_ram_read_arbiter: RTL

- Shares the single AXI read channel (AR + R) of the on-chip AXI RAM between NUM_REQ requesters, e.g. instruction fetch, data load and debug.
- Round-robin arbitration with exactly one read in flight.
- Captures the returned beat and routes it back to the requester that issued it.
- Sits between the core-side request ports and the RAM read ports. The write channel is not handled here.

---
 rtl/axi_ram_read_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/axi_ram_read_arbiter.sv
// Round-robin arbiter sharing the AXI RAM read channel (AR + R) between
// NUM_REQ requesters, with a single read in flight and the beat routed back to its owner.
module axi_ram_read_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 17,
  parameter int DATA_BITS = 64,
  localparam int ID_BITS  = $clog2(NUM_REQ)
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  output logic [NUM_REQ-1:0]             rsp_valid,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  output logic [DATA_BITS-1:0]           rsp_data,
  output logic                           m_arvalid,
  input  logic                           m_arready,
  output logic [ADDR_BITS-1:0]           m_araddr,
  input  logic                           m_rvalid,
  output logic                           m_rready,
  input  logic [DATA_BITS-1:0]           m_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t               state, state_d;
  logic [ID_BITS-1:0]   last, last_d, owner, owner_d;
  logic [ID_BITS-1:0]   grant, cand_id;
  int                   cand;
  logic                 found;
  logic [ADDR_BITS-1:0] grant_addr, m_araddr_d;
  logic [NUM_REQ-1:0]   req_ready_d, rsp_valid_d;
  logic                 m_arvalid_d, m_rready_d;
  logic [DATA_BITS-1:0] rsp_data_d;

  // Scan last+1, last+2, ... (mod NUM_REQ) and take the first pending requester.
  always_comb begin
    found   = 1'b0;
    grant   = last;
    cand    = 0;
    cand_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_id = ID_BITS'(cand);
      if (!found && req_valid[cand_id]) begin
        found = 1'b1;
        grant = cand_id;
      end
    end
  end

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_BITS'(i)) grant_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  always_comb begin
    state_d     = state;
    last_d      = last;
    owner_d     = owner;
    req_ready_d = '0;
    rsp_valid_d = rsp_valid;
    m_arvalid_d = m_arvalid;
    m_rready_d  = m_rready;
    m_araddr_d  = m_araddr;
    rsp_data_d  = rsp_data;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready_d = NUM_REQ'(1) << grant;
          m_araddr_d  = grant_addr;
          owner_d     = grant;
          last_d      = grant;
          m_arvalid_d = 1'b1;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          m_arvalid_d = 1'b0;
          m_rready_d  = 1'b1;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (m_rvalid) begin
          rsp_data_d  = m_rdata;
          m_rready_d  = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << owner;
          state_d     = RESP;
        end
      end
      RESP: begin
        // Only the owner's ready completes the transaction.
        if (rsp_ready[owner]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      last      <= ID_BITS'(NUM_REQ - 1);
      owner     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_araddr  <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_d;
      last      <= last_d;
      owner     <= owner_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      m_arvalid <= m_arvalid_d;
      m_rready  <= m_rready_d;
      m_araddr  <= m_araddr_d;
      rsp_data  <= rsp_data_d;
    end
  end

  a_req_ready_onehot: assert property (@(posedge clock) disable iff (!resetn) $onehot0(req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clock) disable iff (!resetn) $onehot0(rsp_valid));
  a_ar_r_exclusive:   assert property (@(posedge clock) disable iff (!resetn) !(m_arvalid && m_rready));
  a_araddr_stable:    assert property (@(posedge clock) disable iff (!resetn)
                                       (m_arvalid && !m_arready) |=> $stable(m_araddr));
  a_rsp_data_stable:  assert property (@(posedge clock) disable iff (!resetn)
                                       (|rsp_valid) |=> $stable(rsp_data));

endmodule
